// File: rtl/hmmm_controller_mc.sv
// hmmm_controller_mc
//   Multicycle control unit for the HMMM datapath. Fetches the opcode field
//   over a variable-latency memory port with a ready handshake, then
//   sequences each instruction through FETCH / EXEC / MEM and drives the
//   datapath selects. A wait counter converts a memory port that stays
//   not-ready for too long into a sticky FAULT.
//
//   Optional feature macro: HMMM_CTRL_HALT_EN
//     defined   : an all-zero opcode (funct 0000, zero tag) parks the
//                 controller in HALT until reset.
//     undefined : that opcode is a NOP and the HALT state is not built.
//
// Parameters
//   OP_W         opcode field width (>= 4); funct is the top 4 bits
//   MEM_WAIT_MAX longest tolerated run of not-ready cycles, 0 = no timeout
//
// Ports
//   ph1            clock, rising edge
//   reset          asynchronous, active-high; forces every output to 0
//   mem_op_in      opcode field of memory read data
//   mem_ready      memory completes the current request this cycle
//   negative, zero flags for conditional branches
//   instr_op       instruction register
//   mem_req        memory request active
//   mem_write      store request (only with mem_req)
//   adr_src        0 = PC, 1 = data address
//   pc_enable      one-cycle PC update strobe
//   pc_src         00 = PC+1, 01 = branch target, 10 = register
//   ra1_src, two_regs, alu_sub, reg_wload_src   datapath selects
//   reg_write      register-file write strobe
//   reg_write_src  00 = immediate, 01 = read data, 10 = ALU result
//   fault          sticky memory-timeout indication
//   halted         controller stopped (FAULT or HALT)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_FETCH | request opcode at PC, load IR on mem_ready
// ST_EXEC  | decode IR: branch / ALU / immediate retire, memory op -> MEM
// ST_MEM   | load/store at data address, retire on mem_ready
// ST_FAULT | memory timeout; everything quiet until reset
// ST_HALT  | HALT instruction executed (macro builds only)

module hmmm_controller_mc #(
    parameter int OP_W         = 7,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic [OP_W-1:0] mem_op_in,
    input  logic            mem_ready,
    input  logic            negative,
    input  logic            zero,
    output logic [OP_W-1:0] instr_op,
    output logic            mem_req,
    output logic            mem_write,
    output logic            adr_src,
    output logic            pc_enable,
    output logic [1:0]      pc_src,
    output logic            ra1_src,
    output logic            two_regs,
    output logic            alu_sub,
    output logic            reg_wload_src,
    output logic            reg_write,
    output logic [1:0]      reg_write_src,
    output logic            fault,
    output logic            halted
);

    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_WAIT_MAX);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
`ifdef HMMM_CTRL_HALT_EN
        ST_HALT  = 3'd4,
`endif
        ST_FAULT = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  instr_op_q, instr_op_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [3:0] funct;
    logic       br_cond;
    logic       timeout_hit;

    // Internal (ungated) strobes; the output block forces them low in reset.
    logic       req, adr, wr_mem, pce, ra1, rw, flt, hlt;
    logic [1:0] pcs;

    assign funct = instr_op_q[OP_W-1 -: 4];

    always_comb begin
        case (funct[1:0])
            2'b00:   br_cond = zero;
            2'b01:   br_cond = ~zero;
            2'b10:   br_cond = ~negative & ~zero;
            default: br_cond = negative;
        endcase
    end

    assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_cnt_q == CNT_LIMIT);

    always_comb begin
        state_d    = state_q;
        instr_op_d = instr_op_q;
        req        = 1'b0;
        adr        = 1'b0;
        wr_mem     = 1'b0;
        pce        = 1'b0;
        pcs        = 2'b00;
        ra1        = 1'b0;
        rw         = 1'b0;
        flt        = 1'b0;
        hlt        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    instr_op_d = mem_op_in;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (funct[3]) begin
                    ra1 = 1'b1;
                    pce = 1'b1;
                    if (funct[2] | br_cond) begin
                        pcs = (funct[2] & funct[1]) ? 2'b10 : 2'b01;
                    end
                    state_d = ST_FETCH;
                end else if (funct[3:1] == 3'b001) begin
                    state_d = ST_MEM;
`ifdef HMMM_CTRL_HALT_EN
                end else if (instr_op_q == '0) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    rw      = funct[2] | funct[0];
                    pce     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                req    = 1'b1;
                adr    = 1'b1;
                wr_mem = (funct == 4'b0010);
                if (mem_ready) begin
                    rw      = funct[0];
                    pce     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                flt = 1'b1;
                hlt = 1'b1;
            end
`ifdef HMMM_CTRL_HALT_EN
            ST_HALT: begin
                hlt = 1'b1;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Timeout overrides whatever the memory state wanted to do.
        if (req && !mem_ready && timeout_hit) begin
            state_d = ST_FAULT;
        end
    end

    // Counter restarts on every state change and every completed request;
    // it saturates rather than wrapping (only reachable with the timeout off).
    always_comb begin
        if ((state_d != state_q) || mem_ready) begin
            wait_cnt_d = '0;
        end else if (req && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            instr_op_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_op_q <= instr_op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Everything is held at 0 while reset is high, even though the reset
    // state (FETCH) would otherwise be requesting memory.
    always_comb begin
        instr_op      = instr_op_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        pc_enable     = 1'b0;
        pc_src        = 2'b00;
        ra1_src       = 1'b0;
        two_regs      = 1'b0;
        alu_sub       = 1'b0;
        reg_wload_src = 1'b0;
        reg_write     = 1'b0;
        reg_write_src = 2'b00;
        fault         = 1'b0;
        halted        = 1'b0;
        if (!reset) begin
            mem_req       = req;
            mem_write     = wr_mem;
            adr_src       = adr;
            pc_enable     = pce;
            pc_src        = pcs;
            ra1_src       = ra1;
            two_regs      = funct[1];
            alu_sub       = funct[0];
            reg_wload_src = (funct == 4'b0011);
            reg_write     = rw;
            reg_write_src = funct[2] ? 2'b10 : (funct[1] ? 2'b01 : 2'b00);
            fault         = flt;
            halted        = hlt;
        end
    end

endmodule

// File: tb/tb_hmmm_controller_mc.sv
`timescale 1ns/1ps
module tb_hmmm_controller_mc;

    localparam int OP_W = 7;
    localparam int WMAX = 4;

    logic            ph1 = 1'b0;
    logic            reset = 1'b1;
    logic [OP_W-1:0] mem_op_in = '0;
    logic            mem_ready = 1'b0;
    logic            negative = 1'b0;
    logic            zero = 1'b0;
    logic [OP_W-1:0] instr_op;
    logic            mem_req, mem_write, adr_src, pc_enable;
    logic [1:0]      pc_src;
    logic            ra1_src, two_regs, alu_sub, reg_wload_src, reg_write;
    logic [1:0]      reg_write_src;
    logic            fault, halted;

    hmmm_controller_mc #(.OP_W(OP_W), .MEM_WAIT_MAX(WMAX)) dut (
        .ph1(ph1), .reset(reset), .mem_op_in(mem_op_in), .mem_ready(mem_ready),
        .negative(negative), .zero(zero), .instr_op(instr_op), .mem_req(mem_req),
        .mem_write(mem_write), .adr_src(adr_src), .pc_enable(pc_enable),
        .pc_src(pc_src), .ra1_src(ra1_src), .two_regs(two_regs), .alu_sub(alu_sub),
        .reg_wload_src(reg_wload_src), .reg_write(reg_write),
        .reg_write_src(reg_write_src), .fault(fault), .halted(halted)
    );

    always #5 ph1 = ~ph1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one retired instruction.
    typedef struct {
        logic [OP_W-1:0] op;
        int              lat;
        int              req_c;
        int              adr_c;
        int              mw_c;
        int              rw_c;
        logic            rw;
        logic [1:0]      rws;
        logic [1:0]      pcs;
        logic            ra1;
        logic            two;
        logic            sub;
        logic            wls;
    } exp_t;

    exp_t sb[$];

    function automatic logic [OP_W-1:0] mk(input int f, input int t);
        int v;
        v = (f << (OP_W - 4)) | (t & ((1 << (OP_W - 4)) - 1));
        return OP_W'(v);
    endfunction

    // Reference: instruction classes and cycle budget from the ISA rules.
    function automatic exp_t model(input logic [OP_W-1:0] op, input int w1, input int w2,
                                   input logic neg, input logic zr);
        exp_t e;
        int   f;
        bit   is_mem, wr, cond, taken;
        f      = int'(op) >> (OP_W - 4);
        e.op   = op;
        e.pcs  = 2'd0;
        e.ra1  = 1'b0;
        cond   = 1'b0;
        is_mem = (f == 2) || (f == 3);
        if (f >= 8) begin
            case (f % 4)
                0:       cond = zr;
                1:       cond = !zr;
                2:       cond = !neg && !zr;
                default: cond = neg;
            endcase
            taken = (f >= 12) || cond;
            e.ra1 = 1'b1;
            e.pcs = !taken ? 2'd0 : ((f >= 14) ? 2'd2 : 2'd1);
            wr    = 1'b0;
        end else if (is_mem) begin
            wr = (f == 3);
        end else begin
            wr = (f >= 4) || (f % 2 == 1);
        end
        e.rw    = wr;
        e.rw_c  = wr ? 1 : 0;
        e.lat   = 2 + w1 + (is_mem ? 1 + w2 : 0);
        e.req_c = 1 + w1 + (is_mem ? 1 + w2 : 0);
        e.adr_c = is_mem ? 1 + w2 : 0;
        e.mw_c  = (f == 2) ? 1 + w2 : 0;
        e.rws   = ((f % 8) >= 4) ? 2'd2 : (((f % 4) >= 2) ? 2'd1 : 2'd0);
        e.two   = ((f / 2) % 2) != 0;
        e.sub   = (f % 2) != 0;
        e.wls   = (f == 3);
        return e;
    endfunction

    // Monitor: accumulates per-instruction activity, checks at each retirement.
    bit   mon_en = 1'b0;
    int   cyc, last, c_req, c_adr, c_mw, c_rw;
    exp_t me;

    always @(negedge ph1) begin
        if (reset) begin
            cyc = 0; last = 0; c_req = 0; c_adr = 0; c_mw = 0; c_rw = 0;
        end else if (mon_en) begin
            cyc++;
            c_req += int'(mem_req);
            c_adr += int'(adr_src);
            c_mw  += int'(mem_write);
            c_rw  += int'(reg_write);
            check("quiet_flags", {29'd0, fault, halted, mem_write & ~mem_req}, 32'd0);
            if (pc_enable) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL retire: pc_enable at cycle %0d with nothing expected", cyc);
                end else begin
                    me = sb.pop_front();
                    check("instr_op",      32'(instr_op),      32'(me.op));
                    check("latency",       32'(cyc - last),    32'(me.lat));
                    check("reg_write",     32'(reg_write),     32'(me.rw));
                    check("reg_write_src", 32'(reg_write_src), 32'(me.rws));
                    check("pc_src",        32'(pc_src),        32'(me.pcs));
                    check("ra1_src",       32'(ra1_src),       32'(me.ra1));
                    check("two_regs",      32'(two_regs),      32'(me.two));
                    check("alu_sub",       32'(alu_sub),       32'(me.sub));
                    check("reg_wload_src", 32'(reg_wload_src), 32'(me.wls));
                    check("req_cycles",    32'(c_req),         32'(me.req_c));
                    check("adr_cycles",    32'(c_adr),         32'(me.adr_c));
                    check("mw_cycles",     32'(c_mw),          32'(me.mw_c));
                    check("rw_cycles",     32'(c_rw),          32'(me.rw_c));
                end
                last = cyc; c_req = 0; c_adr = 0; c_mw = 0; c_rw = 0;
            end
        end
    end

    task automatic cyc_drive(input logic rdy, input logic [OP_W-1:0] op,
                             input logic neg, input logic zr);
        mem_ready = rdy;
        mem_op_in = op;
        negative  = neg;
        zero      = zr;
        @(posedge ph1);
        #1;
    endtask

    // Drives the memory side on the reference timing; the monitor judges the DUT.
    task automatic run_instr(input logic [OP_W-1:0] op, input int w1, input int w2,
                             input logic neg, input logic zr);
        int f;
        f = int'(op) >> (OP_W - 4);
        sb.push_back(model(op, w1, w2, neg, zr));
        for (int i = 0; i < w1; i++) cyc_drive(1'b0, OP_W'($urandom), neg, zr);
        cyc_drive(1'b1, op, neg, zr);
        cyc_drive(1'($urandom), OP_W'($urandom), neg, zr);
        if (f == 2 || f == 3) begin
            for (int i = 0; i < w2; i++) cyc_drive(1'b0, OP_W'($urandom), neg, zr);
            cyc_drive(1'b1, OP_W'($urandom), neg, zr);
        end
    endtask

    task automatic do_reset();
        @(posedge ph1);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge ph1);
        @(posedge ph1);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OP_W-1:0] rop;
        int              w1, w2;

        // Reset in the middle of a FETCH wait, after IR holds a nonzero opcode.
        repeat (2) @(posedge ph1);
        #1;
        reset = 1'b0;
        cyc_drive(1'b1, mk(7, 7), 1'b0, 1'b0);
        cyc_drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1);
            check("p1_wait_req", 32'(mem_req), 32'd1);
            check("p1_wait_wsrc", 32'(reg_write_src), 32'd2);
            @(posedge ph1);
            #1;
        end
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_op_in = mk(6, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge ph1);
            check("p1_reset_outs",
                  32'({instr_op, mem_req, mem_write, adr_src, pc_enable, pc_src, ra1_src,
                       two_regs, alu_sub, reg_wload_src, reg_write, reg_write_src,
                       fault, halted}), 32'd0);
            @(posedge ph1);
            #1;
        end
        mem_ready = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < WMAX + 1; i++) begin
            @(negedge ph1);
            check("p1_post_req", 32'({mem_req, adr_src, fault}), 32'b100);
            if (i == 0) check("p1_post_ir", 32'(instr_op), 32'd0);
            @(posedge ph1);
            #1;
        end

        // Scoreboarded instruction stream.
        @(posedge ph1);
        #1;
        reset  = 1'b1;
        @(posedge ph1);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        run_instr(mk(6, 5), 0, 0, 1'b0, 1'b0);
        run_instr(mk(3, 1), 0, 2, 1'b0, 1'b0);
        run_instr(mk(2, 2), 1, 1, 1'b0, 1'b0);
        run_instr(mk(11, 0), 0, 0, 1'b1, 1'b0);
        run_instr(mk(11, 0), 0, 0, 1'b0, 1'b0);
        run_instr(mk(14, 3), 0, 0, 1'b0, 1'b1);
        run_instr(mk(3, 0), WMAX, WMAX, 1'b0, 1'b0);
        run_instr(mk(2, 7), WMAX, WMAX, 1'b1, 1'b1);
`ifndef HMMM_CTRL_HALT_EN
        run_instr(mk(0, 0), 2, 0, 1'b0, 1'b0);
`endif
        for (int n = 0; n < 150; n++) begin
            rop = OP_W'($urandom);
`ifdef HMMM_CTRL_HALT_EN
            if (rop == '0) rop = mk(1, 0);
`endif
            w1 = ($urandom_range(0, 3) == 0) ? WMAX : $urandom_range(0, WMAX);
            w2 = $urandom_range(0, WMAX);
            run_instr(rop, w1, w2, 1'($urandom), 1'($urandom));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;

        // Timeout: mem_ready held low in FETCH.
        do_reset();
        for (int i = 1; i <= WMAX + 1; i++) begin
            @(negedge ph1);
            check("p3_waiting", 32'({mem_req, fault, halted}), 32'b100);
            @(posedge ph1);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom);
            @(negedge ph1);
            check("p3_fault", 32'({fault, halted, mem_req, pc_enable, reg_write, mem_write}),
                  32'b110000);
            @(posedge ph1);
            #1;
        end
        do_reset();
        @(negedge ph1);
        check("p3_recover", 32'({fault, halted, mem_req}), 32'b001);

`ifdef HMMM_CTRL_HALT_EN
        // HALT: opcode 0 stops the controller after EXEC.
        do_reset();
        cyc_drive(1'b1, '0, 1'b0, 1'b0);
        @(negedge ph1);
        check("p4_exec", 32'({halted, pc_enable, mem_req}), 32'b000);
        @(posedge ph1);
        #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge ph1);
            check("p4_halt", 32'({halted, fault, pc_enable, mem_req, reg_write}), 32'b10000);
            @(posedge ph1);
            #1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hmmm_controller_mc.md
# hmmm_controller_mc

Multicycle control unit for the HMMM datapath, the parametrised successor to the two-state `controller`. It fetches over a variable-latency memory port with a ready handshake and latches the opcode field into an instruction register. It sequences each instruction through FETCH / EXEC / MEM, driving the same datapath selects as before. It also adds a memory-timeout fault state and an optional HALT instruction.

## Interface
Parameters:
- `OP_W`, default 7: opcode field width, ≥ 4. `funct = instr_op[OP_W-1 -: 4]`; the low `OP_W-4` bits are the operand tag.
- `MEM_WAIT_MAX`, default 15: maximum tolerated consecutive not-ready cycles. 0 disables the timeout.

Ports:
- `ph1`: in, 1. Single clock, rising-edge.
- `reset`: in, 1. Asynchronous, active-high.
- `mem_op_in`: in, OP_W. Opcode field of memory read data.
- `mem_ready`: in, 1. Memory completes the current request this cycle.
- `negative`, `zero`: in, 1 each. ALU/register flags for conditional branches.
- `instr_op`: out, OP_W. Instruction register contents.
- `mem_req`: out, 1. Memory request active.
- `mem_write`: out, 1. Store request; only ever asserted with `mem_req`.
- `adr_src`: out, 1. Address select: 0 = PC, 1 = data address.
- `pc_enable`: out, 1. One-cycle PC update strobe.
- `pc_src`: out, 2. PC source: 00 = PC+1, 01 = branch target, 10 = register.
- `ra1_src`, `two_regs`, `alu_sub`, `reg_wload_src`: out, 1 each. Datapath selects.
- `reg_write`: out, 1. Register-file write strobe.
- `reg_write_src`: out, 2. Write-back source: 00 = immediate, 01 = read data, 10 = ALU result.
- `fault`: out, 1. Sticky memory-timeout indication.
- `halted`: out, 1. Processor stopped (FAULT or HALT state).

## Operation
- States: FETCH, EXEC, MEM, FAULT, and HALT (HALT exists only under the macro below). Reset state is FETCH with the instruction register cleared and the wait counter at 0.
- FETCH:
  - Drives `mem_req=1`, `adr_src=0`.
  - On `mem_ready`, loads `mem_op_in` into the instruction register and moves to EXEC.
- EXEC decodes `instr_op`:
  - **Branch** (`funct[3]=1`): `ra1_src=1`. Taken when `funct[2]` is set, or when the condition below is true. Taken branches select `pc_src=10` if `funct[2]&funct[1]`, else `01`; untaken select `00`. `pc_enable=1`, then go to FETCH.
  - Conditions on `funct[1:0]`: 00 → `zero`; 01 → `~zero`; 10 → `~negative&~zero`; 11 → `negative`.
  - **Memory op** (`funct=001x`): go to MEM, no strobes.
  - **Otherwise**: `reg_write = funct[2]|funct[0]`, `pc_enable=1`, then go to FETCH.
- MEM:
  - Drives `mem_req=1`, `adr_src=1`, and `mem_write = (funct==0010)`.
  - On `mem_ready`: `reg_write = funct[0]` (load), `pc_enable=1`, then go to FETCH.
- Always-decoded selects:
  - `reg_write_src` = 10 if `funct[2]`, else 01 if `funct[1]`, else 00.
  - `reg_wload_src = (funct==0011)`, `two_regs=funct[1]`, `alu_sub=funct[0]`.
- Wait counter:
  - Cleared on state entry and on `mem_ready`.
  - Increments each cycle `mem_req & ~mem_ready`.
  - If the counter equals `MEM_WAIT_MAX` (nonzero) and `mem_ready=0`, go to FAULT next cycle.
  - Counter width is `$clog2(MEM_WAIT_MAX+1)`, minimum 1; it never wraps.
- FAULT: every strobe and `mem_req` is 0, `fault=1`, `halted=1`. Only reset exits.
- `reset` asserted in any state, including mid-wait, returns to FETCH. All outputs are 0 while `reset` is high.

## Timing
- Moore outputs from state and IR, except `pc_src`, which also depends on the flags during EXEC. `mem_ready` qualifies the MEM-state strobes combinationally.
- `mem_ready` and `mem_op_in` are sampled on the `ph1` edge while `mem_req` is high.
- Latency with zero wait states:
  - ALU, immediate, or branch instruction: 2 cycles.
  - Load or store: 3 cycles.
  - Each not-ready cycle adds 1.
- `pc_enable` pulses exactly once per retired instruction.
- `mem_write` is never high for more than the accepting cycle plus wait cycles of one store.

## Configuration
- `HMMM_CTRL_HALT_EN` defined: `funct=0000` with an all-zero operand tag enters HALT from EXEC.
  - No `pc_enable`, `halted=1`, all strobes 0; only reset exits.
- Undefined: that encoding is a NOP (`pc_enable=1`, no write), `halted` is driven only by FAULT, and the HALT state is not built.

## Test plan
- Reset mid-FETCH wait (3 not-ready cycles): all outputs 0 during reset; after release, `mem_req=1`, `adr_src=0`, counter restarts at 0.
- ALU op `funct=0110` with immediate ready: EXEC on cycle 2 with `reg_write=1`, `reg_write_src=10`, `two_regs=1`, `pc_enable=1`.
- Load `funct=0011` with ready delayed 2 cycles in MEM: `adr_src=1`, `reg_write=1`, `reg_wload_src=1`, retires on cycle 5.
- Store `funct=0010`: `mem_write=1` only in MEM; `reg_write=0` throughout.
- Branch `funct=1011` with `negative=1` → `pc_src=01`; with `negative=0` → `pc_src=00`. Branch `funct=1110` → `pc_src=10`. `pc_enable=1` in EXEC for all three.
- `MEM_WAIT_MAX=4`, `mem_ready` held low: FAULT entered after the 5th not-ready cycle; `fault=halted=1` and `mem_req=0` until reset. Under the macro, opcode 0 gives `halted=1` and no further fetch.
